// File: rtl/vicii_pkg.sv
// Shared VIC-II constants: register addresses, colour width, sprite count.
// No logic, so no latency or backpressure of its own.
package vicii_pkg;

    localparam int COLOR_W  = 4;
    localparam int NSPR_DEF = 8;

    localparam logic [15:0] ADDR_MDP = 16'hD01B;
    localparam logic [15:0] ADDR_MM  = 16'hD01E;
    localparam logic [15:0] ADDR_MD  = 16'hD01F;
    localparam logic [15:0] ADDR_EC  = 16'hD020;

endpackage

// File: rtl/vicii_sprite_prio_enc.sv
// Sprite priority encoder: lowest set index wins, plus any/multi-hit flags.
// Purely combinational; no flow control.
module vicii_sprite_prio_enc
    import vicii_pkg::*;
#(
    parameter int NSPR = NSPR_DEF,
    parameter int WW   = (NSPR > 1) ? $clog2(NSPR) : 1
) (
    input  logic [NSPR-1:0] en,
    output logic            any_en,
    output logic [WW-1:0]   w,
    output logic            multi_hit
);

    logic [3:0] cnt;

    // Scan from the top down so the lowest enabled index is written last.
    always_comb begin
        w   = '0;
        cnt = 4'd0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            cnt = cnt + {3'b000, en[i]};
            if (en[i]) begin
                w = i[WW-1:0];
            end
        end
    end

    assign any_en    = |en;
    assign multi_hit = (cnt >= 4'd2);

endmodule

// File: rtl/vicii_sprite_mux.sv
// Sprite/background/border colour mux with clear-on-read collision latches and IRQ pulses.
// One-cycle registered latency on every output; never stalls.
module vicii_sprite_mux
    import vicii_pkg::*;
#(
    parameter int NSPR = NSPR_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSPR-1:0]         spr_en,
    input  logic [COLOR_W*NSPR-1:0] spr_pixel,
    input  logic [COLOR_W-1:0]      gfx_pixel,
    input  logic                    gfx_fg,
    input  logic                    border,
    input  logic [COLOR_W-1:0]      EC,
    input  logic [NSPR-1:0]         MDP,
    input  logic                    rd_mm,
    input  logic                    rd_md,
    output logic [COLOR_W-1:0]      pixel_out,
    output logic [NSPR-1:0]         mm,
    output logic [NSPR-1:0]         md,
    output logic                    irq_mmc,
    output logic                    irq_mbc
);

    localparam int WW = (NSPR > 1) ? $clog2(NSPR) : 1;

    logic            any_en;
    logic [WW-1:0]   w;
    logic            multi_hit;
    logic [COLOR_W-1:0] win_pixel;
    logic [COLOR_W-1:0] pixel_nxt;
    logic [NSPR-1:0] cmm;
    logic [NSPR-1:0] cmd;
    logic [NSPR-1:0] mm_base;
    logic [NSPR-1:0] md_base;

    vicii_sprite_prio_enc #(.NSPR(NSPR), .WW(WW)) u_prio (
        .en        (spr_en),
        .any_en    (any_en),
        .w         (w),
        .multi_hit (multi_hit)
    );

    always_comb begin
        win_pixel = '0;
        for (int i = 0; i < NSPR; i++) begin
            if (w == i[WW-1:0]) begin
                win_pixel = spr_pixel[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        pixel_nxt = win_pixel;
        if (border) begin
            pixel_nxt = EC;
        end else if (!any_en) begin
            pixel_nxt = gfx_pixel;
        end else if (MDP[w] && gfx_fg) begin
            pixel_nxt = gfx_pixel;
        end
    end

    // Border pixels are invisible, so they never count as collisions.
    assign cmm = (!border && multi_hit) ? spr_en : '0;
    assign cmd = (!border && gfx_fg)    ? spr_en : '0;

    // A read clears the old contents but a coincident hit is still latched.
    assign mm_base = rd_mm ? '0 : mm;
    assign md_base = rd_md ? '0 : md;

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out <= '0;
            mm        <= '0;
            md        <= '0;
            irq_mmc   <= 1'b0;
            irq_mbc   <= 1'b0;
        end else begin
            pixel_out <= pixel_nxt;
            mm        <= mm_base | cmm;
            md        <= md_base | cmd;
            irq_mmc   <= (mm_base == '0) && (cmm != '0);
            irq_mbc   <= (md_base == '0) && (cmd != '0);
        end
    end

endmodule

// File: tb/tb_vicii_sprite_mux.sv
// Directed vector bench for vicii_sprite_mux: a sequential table of inputs with
// expected post-edge outputs, plus a hand-written sequence for IRQ repetition.
module tb_vicii_sprite_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  spr_en;
    logic [31:0] spr_pixel;
    logic [3:0]  gfx_pixel;
    logic        gfx_fg;
    logic        border;
    logic [3:0]  EC;
    logic [7:0]  MDP;
    logic        rd_mm;
    logic        rd_md;
    logic [3:0]  pixel_out;
    logic [7:0]  mm;
    logic [7:0]  md;
    logic        irq_mmc;
    logic        irq_mbc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vicii_sprite_mux #(.NSPR(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .spr_en    (spr_en),
        .spr_pixel (spr_pixel),
        .gfx_pixel (gfx_pixel),
        .gfx_fg    (gfx_fg),
        .border    (border),
        .EC        (EC),
        .MDP       (MDP),
        .rd_mm     (rd_mm),
        .rd_md     (rd_md),
        .pixel_out (pixel_out),
        .mm        (mm),
        .md        (md),
        .irq_mmc   (irq_mmc),
        .irq_mbc   (irq_mbc)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  en;
        logic [31:0] sp;
        logic [3:0]  gp;
        logic        fg;
        logic        bd;
        logic [3:0]  ec;
        logic [7:0]  mdp;
        logic        rmm;
        logic        rmd;
        logic [3:0]  x_pix;
        logic [7:0]  x_mm;
        logic [7:0]  x_md;
        logic        x_immc;
        logic        x_imbc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [7:0] en, input logic [31:0] sp,
                       input logic [3:0] gp, input logic fg, input logic bd,
                       input logic [3:0] ec, input logic [7:0] mdp,
                       input logic rmm, input logic rmd,
                       input logic [3:0] x_pix, input logic [7:0] x_mm,
                       input logic [7:0] x_md, input logic x_immc, input logic x_imbc);
        vec_t v;
        v.rst = rst; v.en = en; v.sp = sp; v.gp = gp; v.fg = fg; v.bd = bd;
        v.ec = ec; v.mdp = mdp; v.rmm = rmm; v.rmd = rmd;
        v.x_pix = x_pix; v.x_mm = x_mm; v.x_md = x_md;
        v.x_immc = x_immc; v.x_imbc = x_imbc;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; spr_en = v.en; spr_pixel = v.sp; gfx_pixel = v.gp;
        gfx_fg = v.fg; border = v.bd; EC = v.ec; MDP = v.mdp;
        rd_mm = v.rmm; rd_md = v.rmd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step_and_check(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check({tag, ".pixel_out"}, 32'(pixel_out), 32'(v.x_pix));
        check({tag, ".mm"},        32'(mm),        32'(v.x_mm));
        check({tag, ".md"},        32'(md),        32'(v.x_md));
        check({tag, ".irq_mmc"},   32'(irq_mmc),   32'(v.x_immc));
        check({tag, ".irq_mbc"},   32'(irq_mbc),   32'(v.x_imbc));
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; spr_en = '0; spr_pixel = '0; gfx_pixel = '0; gfx_fg = 1'b0;
        border = 1'b0; EC = '0; MDP = '0; rd_mm = 1'b0; rd_md = 1'b0;

        //   rst en     spr_pixel     gp    fg bd ec    mdp    rmm rmd | pix  mm     md     immc imbc
        add(1, 8'h00, 32'h0000_0000, 4'h0, 0, 0, 4'h0, 8'h00, 0, 0,   4'h0, 8'h00, 8'h00, 0, 0); // reset
        add(0, 8'h06, 32'h0000_0520, 4'h3, 0, 0, 4'h0, 8'h00, 0, 0,   4'h2, 8'h06, 8'h00, 1, 0); // prio 1 over 2
        add(0, 8'h00, 32'h0000_0000, 4'h3, 0, 0, 4'h0, 8'h00, 0, 0,   4'h3, 8'h06, 8'h00, 0, 0); // pulse ends
        add(0, 8'h01, 32'h0000_0009, 4'hE, 1, 0, 4'h0, 8'h01, 0, 0,   4'hE, 8'h06, 8'h01, 0, 1); // behind fg
        add(0, 8'h01, 32'h0000_0009, 4'hE, 0, 0, 4'h0, 8'h01, 0, 0,   4'h9, 8'h06, 8'h01, 0, 0); // fg=0 -> sprite
        add(0, 8'h03, 32'h0000_0049, 4'hE, 1, 0, 4'h0, 8'h02, 0, 0,   4'h9, 8'h07, 8'h03, 0, 0); // loser MDP ignored
        add(0, 8'h00, 32'h0000_0000, 4'h1, 0, 0, 4'h0, 8'h00, 1, 1,   4'h1, 8'h00, 8'h00, 0, 0); // clear both
        add(0, 8'h03, 32'h0000_0049, 4'h1, 0, 0, 4'h0, 8'h00, 0, 0,   4'h9, 8'h03, 8'h00, 1, 0); // mm=03
        add(0, 8'h0C, 32'h0000_CA00, 4'h1, 0, 0, 4'h0, 8'h00, 1, 0,   4'hA, 8'h0C, 8'h00, 1, 0); // read+hit
        add(0, 8'h00, 32'h0000_0000, 4'h5, 1, 0, 4'h0, 8'h00, 0, 0,   4'h5, 8'h0C, 8'h00, 0, 0); // no winner
        add(0, 8'hFF, 32'h7654_3210, 4'h5, 1, 1, 4'hB, 8'h00, 0, 0,   4'hB, 8'h0C, 8'h00, 0, 0); // border
        add(0, 8'h80, 32'hD000_0000, 4'h6, 0, 0, 4'h0, 8'h80, 0, 0,   4'hD, 8'h0C, 8'h00, 0, 0); // sprite 7 alone
        add(0, 8'h80, 32'hD000_0000, 4'h6, 1, 0, 4'h0, 8'h80, 0, 0,   4'h6, 8'h0C, 8'h80, 0, 1); // sprite 7 behind
        add(0, 8'h10, 32'h0003_0000, 4'h6, 1, 0, 4'h0, 8'h00, 0, 1,   4'h3, 8'h0C, 8'h10, 0, 1); // rd_md + hit
        add(0, 8'hFF, 32'h0000_0007, 4'h6, 0, 0, 4'h0, 8'h00, 0, 0,   4'h7, 8'hFF, 8'h10, 0, 0); // mm=FF pix 7
        add(1, 8'hFF, 32'h0000_0007, 4'h6, 1, 0, 4'h0, 8'h00, 0, 0,   4'h0, 8'h00, 8'h00, 0, 0); // reset wins
        add(0, 8'h00, 32'h0000_0000, 4'h2, 0, 0, 4'h0, 8'h00, 0, 0,   4'h2, 8'h00, 8'h00, 0, 0); // resume

        foreach (vecs[i]) begin
            step_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Hold a two-sprite overlap: only the first cycle may raise irq_mmc.
        v = '{rst: 0, en: 8'h03, sp: 32'h0000_0021, gp: 4'h4, fg: 0, bd: 0, ec: 4'h0,
              mdp: 8'h00, rmm: 0, rmd: 0, x_pix: 4'h1, x_mm: 8'h03, x_md: 8'h00,
              x_immc: 1, x_imbc: 0};
        for (int c = 0; c < 10; c++) begin
            v.x_immc = (c == 0);
            step_and_check($sformatf("hold%0d", c), v);
        end

        v.en = 8'h00; v.rmm = 1; v.x_pix = 4'h4; v.x_mm = 8'h00; v.x_immc = 0;
        step_and_check("hold_clear", v);

        v.en = 8'h03; v.rmm = 0; v.x_pix = 4'h1; v.x_mm = 8'h03; v.x_immc = 1;
        step_and_check("hold_refire", v);

        v.x_immc = 0;
        step_and_check("hold_after", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
